// File: rtl/framebuffer_painter.sv
// Double-buffered RGB332 frame store feeding both LED panel halves.
// The loader fills the back buffer; the front buffer flips only on a frame change.
module framebuffer_painter #(
  parameter int FRAME_BITS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic [5:0]            x,
  input  logic [5:0]            y0,
  input  logic [5:0]            y1,
  output logic [23:0]           rgb24_0,
  output logic [23:0]           rgb24_1,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  wr_sof,
  input  logic [7:0]            wr_data,
  output logic                  swap
);

  typedef enum logic {S_FILL, S_PENDING} state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_front, w_front_nxt;
  logic [11:0]             r_wr_addr, w_wr_addr_nxt;
  logic                    r_swap, w_swap_nxt;
  logic [FRAME_BITS-1:0]   r_frame_q;
  logic [7:0]              r_mem_top [4096];
  logic [7:0]              r_mem_bot [4096];

  logic        w_xfer;
  logic        w_frame_chg;
  logic [11:0] w_wr_ptr;
  logic [11:0] w_rd_top;
  logic [11:0] w_rd_bot;
  logic        w_unused;

  function automatic logic [23:0] expand(input logic [7:0] p);
    return {{4{p[1:0]}}, p[4:2], p[4:2], p[4:3], p[7:5], p[7:5], p[7:6]};
  endfunction

  assign wr_ready    = (r_state == S_FILL) && !reset;
  assign w_xfer      = wr_valid && wr_ready;
  assign w_wr_ptr    = wr_sof ? 12'd0 : r_wr_addr;
  assign w_frame_chg = (frame != r_frame_q);
  assign w_rd_top    = {r_front, y0[4:0], x};
  assign w_rd_bot    = {r_front, y1[4:0], x};
  assign w_unused    = ^{y0[5], y1[5]};
  assign swap        = r_swap;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt   = r_state;
    w_front_nxt   = r_front;
    w_wr_addr_nxt = r_wr_addr;
    w_swap_nxt    = 1'b0;
    case (r_state)
      S_FILL: begin
        if (w_xfer) begin
          w_wr_addr_nxt = w_wr_ptr + 12'd1;
          if (!wr_sof && (r_wr_addr == 12'hFFF)) w_state_nxt = S_PENDING;
        end
      end
      S_PENDING: begin
        if (w_frame_chg) begin
          w_front_nxt = !r_front;
          w_swap_nxt  = 1'b1;
          w_state_nxt = S_FILL;
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FILL;
      r_front   <= 1'b0;
      r_wr_addr <= 12'd0;
      r_swap    <= 1'b0;
      r_frame_q <= frame;
    end else begin
      r_state   <= w_state_nxt;
      r_front   <= w_front_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_swap    <= w_swap_nxt;
      r_frame_q <= frame;
    end
  end

  // NOTE: the arrays have no reset so they map onto block RAM; reset only clears the control path.
  always_ff @(posedge clk) begin
    if (w_xfer && !w_wr_ptr[11]) r_mem_top[{!r_front, w_wr_ptr[10:0]}] <= wr_data;
    if (w_xfer &&  w_wr_ptr[11]) r_mem_bot[{!r_front, w_wr_ptr[10:0]}] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb24_0 <= 24'd0;
      rgb24_1 <= 24'd0;
    end else begin
      rgb24_0 <= expand(r_mem_top[w_rd_top]);
      rgb24_1 <= expand(r_mem_bot[w_rd_bot]);
    end
  end

endmodule

// File: tb/tb_framebuffer_painter.sv
// Directed bench for framebuffer_painter: fill, swap, stall, sof restart, frame churn, reset.
module tb_framebuffer_painter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  frame = 10'd0;
  logic [5:0]  x = 6'd0, y0 = 6'd0, y1 = 6'd32;
  logic [23:0] rgb24_0, rgb24_1;
  logic        wr_valid = 1'b0, wr_ready, wr_sof = 1'b0, swap;
  logic [7:0]  wr_data = 8'd0;

  int n_pass = 0;
  int n_total = 0;
  int swap_cnt = 0;
  int tb_addr = 0;

  framebuffer_painter #(.FRAME_BITS(10)) dut (
    .clk(clk), .reset(reset), .frame(frame), .x(x), .y0(y0), .y1(y1),
    .rgb24_0(rgb24_0), .rgb24_1(rgb24_1), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_sof(wr_sof), .wr_data(wr_data), .swap(swap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (swap === 1'b1) swap_cnt++;
  endtask

  task automatic read_px(input logic [5:0] xx, input logic [5:0] yy0, input logic [5:0] yy1);
    x = xx; y0 = yy0; y1 = yy1;
    tick();
  endtask

  // Streams n pixels; first pixel may carry sof. Data is chosen by the half the pixel lands in.
  task automatic stream(input string tag, input int n, input bit sof_first, input logic [7:0] first_val,
                        input logic [7:0] lo_val, input logic [7:0] hi_val, input bit churn);
    int stalls = 0;
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_sof   = (i == 0) && sof_first;
      if (wr_sof) tb_addr = 0;
      wr_data  = (i == 0) ? first_val : ((tb_addr < 2048) ? lo_val : hi_val);
      if (churn && (i % 10) == 5) frame = (i == n - 1) ? 10'h3FF : frame + 10'd1;
      if (wr_ready !== 1'b1) stalls++;
      tick();
      tb_addr = (tb_addr + 1) % 4096;
    end
    wr_valid = 1'b0;
    wr_sof   = 1'b0;
    n_total++;
    if (stalls != 0) $display("FAIL %s_stalls: got %0d stalled cycles, expected 0", tag, stalls);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; x = 6'd5; y0 = 6'd3; y1 = 6'd35;
    tick(); tick();
    n_total++; if (wr_ready !== 1'b0) $display("FAIL reset_ready_low: got %b expected 0", wr_ready); else n_pass++;
    reset = 1'b0;
    tick();
    n_total++; if (rgb24_0 !== 24'h000000) $display("FAIL reset_rgb0: got %h expected 000000", rgb24_0); else n_pass++;
    n_total++; if (rgb24_1 !== 24'h000000) $display("FAIL reset_rgb1: got %h expected 000000", rgb24_1); else n_pass++;
    n_total++; if (wr_ready !== 1'b1) $display("FAIL reset_ready_high: got %b expected 1", wr_ready); else n_pass++;
    n_total++; if (swap !== 1'b0) $display("FAIL reset_swap: got %b expected 0", swap); else n_pass++;
  endtask

  task automatic test_full_image();
    swap_cnt = 0;
    stream("full", 4096, 1'b1, 8'hE0, 8'hE0, 8'h03, 1'b0);
    n_total++; if (wr_ready !== 1'b0) $display("FAIL full_pending_ready: got %b expected 0", wr_ready); else n_pass++;
    n_total++; if (swap_cnt != 0) $display("FAIL full_early_swap: got %0d expected 0", swap_cnt); else n_pass++;
    x = 6'd0; y0 = 6'd0; y1 = 6'd32; frame = frame + 10'd1;
    tick();
    n_total++; if (swap !== 1'b1) $display("FAIL full_swap_pulse: got %b expected 1", swap); else n_pass++;
    n_total++; if (rgb24_0 !== 24'h000000) $display("FAIL full_old_front_read: got %h expected 000000", rgb24_0); else n_pass++;
    tick();
    n_total++; if (rgb24_0 !== 24'h0000FF) $display("FAIL full_rgb0: got %h expected 0000FF", rgb24_0); else n_pass++;
    n_total++; if (rgb24_1 !== 24'hFF0000) $display("FAIL full_rgb1: got %h expected FF0000", rgb24_1); else n_pass++;
    n_total++; if (swap !== 1'b0) $display("FAIL full_swap_one_cycle: got %b expected 0", swap); else n_pass++;
    n_total++; if (wr_ready !== 1'b1) $display("FAIL full_ready_after_swap: got %b expected 1", wr_ready); else n_pass++;
  endtask

  task automatic test_stall();
    int ready_hi = 0;
    stream("stall_fill", 4096, 1'b1, 8'h1C, 8'h1C, 8'h1C, 1'b0);
    swap_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      wr_valid = 1'b1; wr_sof = i[0]; wr_data = 8'h00;
      if (wr_ready === 1'b1) ready_hi++;
      tick();
    end
    wr_valid = 1'b0; wr_sof = 1'b0;
    n_total++; if (ready_hi != 0) $display("FAIL stall_ready: got %0d ready cycles expected 0", ready_hi); else n_pass++;
    n_total++; if (swap_cnt != 0) $display("FAIL stall_swap: got %0d expected 0", swap_cnt); else n_pass++;
    read_px(6'd0, 6'd0, 6'd32);
    n_total++; if (rgb24_0 !== 24'h0000FF) $display("FAIL stall_display_kept: got %h expected 0000FF", rgb24_0); else n_pass++;
    frame = frame + 10'd1; tick();
    read_px(6'd0, 6'd0, 6'd32);
    n_total++; if (rgb24_0 !== 24'h00FF00) $display("FAIL stall_no_write_top: got %h expected 00FF00", rgb24_0); else n_pass++;
    n_total++; if (rgb24_1 !== 24'h00FF00) $display("FAIL stall_no_write_bot: got %h expected 00FF00", rgb24_1); else n_pass++;
  endtask

  task automatic test_sof_restart();
    swap_cnt = 0;
    stream("sof_pre", 100, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    stream("sof_main", 4095, 1'b1, 8'h1C, 8'h00, 8'h00, 1'b0);
    n_total++; if (wr_ready !== 1'b1) $display("FAIL sof_not_done_at_4095: got %b expected 1", wr_ready); else n_pass++;
    stream("sof_last", 1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    n_total++; if (wr_ready !== 1'b0) $display("FAIL sof_done_at_4096: got %b expected 0", wr_ready); else n_pass++;
    n_total++; if (swap_cnt != 0) $display("FAIL sof_early_swap: got %0d expected 0", swap_cnt); else n_pass++;
    frame = frame + 10'd1; tick();
    read_px(6'd0, 6'd0, 6'd32);
    n_total++; if (rgb24_0 !== 24'h00FF00) $display("FAIL sof_pixel0: got %h expected 00FF00", rgb24_0); else n_pass++;
    n_total++; if (rgb24_1 !== 24'h000000) $display("FAIL sof_bot_pixel0: got %h expected 000000", rgb24_1); else n_pass++;
    read_px(6'd35, 6'd1, 6'd33);
    n_total++; if (rgb24_0 !== 24'h000000) $display("FAIL sof_overwritten: got %h expected 000000", rgb24_0); else n_pass++;
  endtask

  task automatic test_frame_churn();
    swap_cnt = 0;
    stream("churn", 4096, 1'b1, 8'hE0, 8'hE0, 8'h03, 1'b1);
    n_total++; if (swap_cnt != 0) $display("FAIL churn_swap_during_fill: got %0d expected 0", swap_cnt); else n_pass++;
    n_total++; if (wr_ready !== 1'b0) $display("FAIL churn_pending: got %b expected 0", wr_ready); else n_pass++;
    for (int i = 0; i < 5; i++) tick();
    n_total++; if (swap_cnt != 0) $display("FAIL churn_final_cycle_swap: got %0d expected 0", swap_cnt); else n_pass++;
    frame = 10'h000; tick();
    n_total++; if (swap_cnt != 1) $display("FAIL churn_wrap_swap: got %0d expected 1", swap_cnt); else n_pass++;
    read_px(6'd63, 6'd31, 6'd63);
    n_total++; if (rgb24_0 !== 24'h0000FF) $display("FAIL churn_rgb0: got %h expected 0000FF", rgb24_0); else n_pass++;
    n_total++; if (rgb24_1 !== 24'hFF0000) $display("FAIL churn_rgb1: got %h expected FF0000", rgb24_1); else n_pass++;
  endtask

  task automatic test_reset_mid_fill();
    stream("rst_partial", 2000, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    reset = 1'b1; tick();
    n_total++; if (wr_ready !== 1'b0) $display("FAIL rst_ready_low: got %b expected 0", wr_ready); else n_pass++;
    n_total++; if (rgb24_0 !== 24'h000000) $display("FAIL rst_rgb_clear: got %h expected 000000", rgb24_0); else n_pass++;
    tick(); reset = 1'b0; tb_addr = 0;
    read_px(6'd0, 6'd0, 6'd32);
    n_total++; if (rgb24_0 !== 24'h0000FF) $display("FAIL rst_front_kept: got %h expected 0000FF", rgb24_0); else n_pass++;
    swap_cnt = 0;
    stream("rst_image", 4096, 1'b1, 8'h1C, 8'h00, 8'h00, 1'b0);
    frame = frame + 10'd1; tick();
    n_total++; if (swap_cnt != 1) $display("FAIL rst_swap: got %0d expected 1", swap_cnt); else n_pass++;
    read_px(6'd0, 6'd0, 6'd32);
    n_total++; if (rgb24_0 !== 24'h00FF00) $display("FAIL rst_new_rgb0: got %h expected 00FF00", rgb24_0); else n_pass++;
    read_px(6'd35, 6'd1, 6'd33);
    n_total++; if (rgb24_0 !== 24'h000000) $display("FAIL rst_stale_overwritten: got %h expected 000000", rgb24_0); else n_pass++;
    // Second reset from front=1: front returns to 0 and the address restarts without any sof.
    stream("rst2_partial", 2000, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    reset = 1'b1; tick(); tick(); reset = 1'b0; tb_addr = 0;
    read_px(6'd0, 6'd0, 6'd32);
    n_total++; if (rgb24_0 !== 24'hFFFFFF) $display("FAIL rst2_front0: got %h expected FFFFFF", rgb24_0); else n_pass++;
    stream("rst2_nosof", 4096, 1'b0, 8'hE0, 8'hE0, 8'h03, 1'b0);
    n_total++; if (wr_ready !== 1'b0) $display("FAIL rst2_pending: got %b expected 0", wr_ready); else n_pass++;
    frame = frame + 10'd1; tick();
    read_px(6'd0, 6'd0, 6'd32);
    n_total++; if (rgb24_0 !== 24'h0000FF) $display("FAIL rst2_rgb0: got %h expected 0000FF", rgb24_0); else n_pass++;
    n_total++; if (rgb24_1 !== 24'hFF0000) $display("FAIL rst2_rgb1: got %h expected FF0000", rgb24_1); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_image();
    test_stall();
    test_sof_restart();
    test_frame_churn();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
